// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - opcode values carried on the 'sub' input
package serial_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fullAdder_1b.sv
// Single-bit full adder cell used by the serial add/subtract unit.
// Ports:
//   A, B   : operand bits
//   C_in   : carry in
//   S      : sum bit
//   C_out  : carry out
module fullAdder_1b (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);

    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit. One full-adder cell processes one bit pair
// per clock, LSB first, so a WIDTH-bit operation takes WIDTH RUN cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one bit pair per clock through the full adder
// DONE  | one-cycle result pulse; a new start is accepted here too
//
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : request a new operation (ignored while busy)
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   busy       : high while bits are processed
//   done       : single-cycle pulse when results update
//   sum        : result of the last completed operation
//   c_out      : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        : two's-complement overflow of the last operation
//   zero       : sum == 0 for the last operation
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;

    fullAdder_1b u_fa (
        .A     (sa[0]),
        .B     (sb[0]),
        .C_in  (carry),
        .S     (fa_s),
        .C_out (fa_cout)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign next_work = {fa_s, work[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sa    <= a;
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        sb    <= (sub == OP_SUB) ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    work  <= next_work;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= ST_DONE;
                        sum   <= next_work;
                        c_out <= fa_cout;
                        // Carry into vs. out of the sign bit disagree on overflow.
                        ovf   <= carry ^ fa_cout;
                        zero  <= (next_work == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with a result scoreboard.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference arithmetic done in W+1 bits, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t         e;
        logic [W:0]   full;
        if (s == OP_SUB) begin
            full  = {1'b0, x} + {1'b0, ~y} + 17'd1;
            e.ovf = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full  = {1'b0, x} + {1'b0, y};
            e.ovf = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end
        e.sum   = full[W-1:0];
        e.c_out = full[W];
        e.zero  = (full[W-1:0] == '0);
        return e;
    endfunction

    // Drive start for one edge, push the expected result, confirm RUN entry.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        sb_q.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done, check latency, sum stability during RUN and results.
    task automatic wait_result(input string tag, input bit hammer);
        int           cycles;
        bit           changed;
        logic [W-1:0] prev;
        exp_t         e;
        cycles  = 1;
        changed = 1'b0;
        prev    = sum;
        while (!done && cycles < 40) begin
            if (sum !== prev) changed = 1'b1;
            if (hammer) begin
                start = busy;
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, 32'd17);
        check({tag, "_sum_hold"}, {31'd0, changed}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.sum});
            check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, e.c_out});
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
        end
    endtask

    task automatic check_pulse_ends(input string tag);
        @(negedge clk);
        check({tag, "_done_1cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_outputs", {12'd0, busy, done, sum, c_out, ovf, zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {12'd0, busy, done, sum, c_out, ovf, zero}, 32'd0);

        start_op(16'h0001, 16'h0001, OP_ADD);
        wait_result("add_1_1", 1'b0);
        check("add_1_1_exact", {16'd0, sum}, 32'h0002);
        check_pulse_ends("add_1_1");

        start_op(16'h7FFF, 16'h0001, OP_ADD);
        wait_result("add_pos_ovf", 1'b0);
        check("add_pos_ovf_flag", {31'd0, ovf}, 32'd1);
        check_pulse_ends("add_pos_ovf");

        start_op(16'hFFFF, 16'h0001, OP_ADD);
        wait_result("add_wrap", 1'b0);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        check_pulse_ends("add_wrap");

        start_op(16'h0005, 16'h0005, OP_SUB);
        wait_result("sub_eq", 1'b0);
        // Back-to-back: start issued in the done cycle itself.
        start_op(16'h0003, 16'h0005, OP_SUB);
        wait_result("sub_neg", 1'b0);
        check("sub_neg_exact", {16'd0, sum}, 32'h0000FFFE);
        check_pulse_ends("sub_neg");

        start_op(16'h1111, 16'h2222, OP_ADD);
        wait_result("start_ignored", 1'b1);
        check_pulse_ends("start_ignored");

        start_op(16'hA5A5, 16'h5A5A, OP_SUB);
        wait_result("sub_mixed", 1'b0);
        check_pulse_ends("sub_mixed");

        // Abort mid-operation with reset; nothing is pushed for this one.
        start = 1'b1;
        a     = 16'h4444;
        b     = 16'h3333;
        sub   = OP_ADD;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {12'd0, busy, done, sum, c_out, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        check("abort_idle", {12'd0, busy, done, sum, c_out, ovf, zero}, 32'd0);

        start_op(16'h1234, 16'h1111, OP_ADD);
        wait_result("post_reset", 1'b0);
        check("post_reset_exact", {16'd0, sum}, 32'h2345);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
